// File: rtl/async_fifo.sv
// Single-clock first-word-fall-through FIFO with wrap-bit pointers and registered flags.
// Define ASYNC_FIFO_LEVEL_EN to add the LEVEL occupancy output.
module async_fifo #(
    parameter int C_WIDTH = 32,
    parameter int C_DEPTH = 8,
    localparam int C_AW = $clog2(C_DEPTH)
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               WR_EN,
    input  logic [C_WIDTH-1:0] WR_DATA,
    output logic               WR_FULL,
    input  logic               RD_EN,
    output logic [C_WIDTH-1:0] RD_DATA,
    output logic               RD_EMPTY
`ifdef ASYNC_FIFO_LEVEL_EN
    ,
    output logic [C_AW:0]      LEVEL
`endif
);

    logic [C_WIDTH-1:0] mem_q [C_DEPTH];
    logic [C_AW:0]      wr_ptr_q, wr_ptr_d;
    logic [C_AW:0]      rd_ptr_q, rd_ptr_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;
    logic               wr_acc_s, rd_acc_s;

    // Next-state pointers and flags; flags are computed from the next pointers so they can be registered.
    always_comb begin
        wr_acc_s = WR_EN & ~full_q & RST_N;
        rd_acc_s = RD_EN & ~empty_q & RST_N;
        if (wr_acc_s) begin
            wr_ptr_d = wr_ptr_q + {{C_AW{1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_acc_s) begin
            rd_ptr_d = rd_ptr_q + {{C_AW{1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        empty_d = (wr_ptr_d == rd_ptr_d);
        full_d  = (wr_ptr_d[C_AW-1:0] == rd_ptr_d[C_AW-1:0]) &&
                  (wr_ptr_d[C_AW] != rd_ptr_d[C_AW]);
    end

    // Pointer and flag registers; reset empties the FIFO without touching storage.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q <= {(C_AW+1){1'b0}};
            rd_ptr_q <= {(C_AW+1){1'b0}};
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage array, deliberately without reset.
    always_ff @(posedge CLK) begin
        if (wr_acc_s) begin
            mem_q[wr_ptr_q[C_AW-1:0]] <= WR_DATA;
        end
    end

    assign RD_DATA  = mem_q[rd_ptr_q[C_AW-1:0]];
    assign WR_FULL  = full_q;
    assign RD_EMPTY = empty_q;

`ifdef ASYNC_FIFO_LEVEL_EN
    logic [C_AW:0] level_q, level_d;

    // Occupancy is the modular pointer difference, registered alongside the pointers.
    always_comb begin
        level_d = wr_ptr_d - rd_ptr_d;
    end

    // Occupancy register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            level_q <= {(C_AW+1){1'b0}};
        end else begin
            level_q <= level_d;
        end
    end

    assign LEVEL = level_q;
`endif

endmodule

// File: tb/tb_async_fifo.sv
// Self-checking bench for async_fifo: directed scenarios plus random traffic against a queue model.
module tb_async_fifo;
    localparam int W  = 32;
    localparam int D  = 8;
    localparam int AW = $clog2(D);

    logic         clk = 1'b0;
    logic         rst_n;
    logic         wr_en;
    logic [W-1:0] wr_data;
    logic         wr_full;
    logic         rd_en;
    logic [W-1:0] rd_data;
    logic         rd_empty;
`ifdef ASYNC_FIFO_LEVEL_EN
    logic [AW:0]  level;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] model_q [$];

    always #5 clk = ~clk;

    async_fifo #(.C_WIDTH(W), .C_DEPTH(D)) dut (
        .CLK      (clk),
        .RST_N    (rst_n),
        .WR_EN    (wr_en),
        .WR_DATA  (wr_data),
        .WR_FULL  (wr_full),
        .RD_EN    (rd_en),
        .RD_DATA  (rd_data),
        .RD_EMPTY (rd_empty)
`ifdef ASYNC_FIFO_LEVEL_EN
        ,
        .LEVEL    (level)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".empty"}, 64'(rd_empty), 64'(model_q.size() == 0));
        check({tag, ".full"}, 64'(wr_full), 64'(model_q.size() == D));
        if (model_q.size() != 0) begin
            check({tag, ".data"}, 64'(rd_data), 64'(model_q[0]));
        end
`ifdef ASYNC_FIFO_LEVEL_EN
        check({tag, ".level"}, 64'(level), 64'(model_q.size()));
`endif
    endtask

    // One clock: drive requests, apply the FIFO rules to the model at the edge, then compare.
    task automatic cycle(input string tag, input logic wr, input logic [W-1:0] wd, input logic rd);
        bit wr_ok, rd_ok;
        wr_en   = wr;
        wr_data = wd;
        rd_en   = rd;
        wr_ok   = wr && (model_q.size() < D);
        rd_ok   = rd && (model_q.size() > 0);
        @(posedge clk);
        if (rd_ok) void'(model_q.pop_front());
        if (wr_ok) model_q.push_back(wd);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        check_state(tag);
    endtask

    task automatic drain();
        int guard = 0;
        while (model_q.size() > 0 && guard < 4 * D) begin
            cycle("drain", 1'b0, '0, 1'b1);
            guard++;
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b1;
        wr_data = 32'hDEAD_BEEF;
        rd_en   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst.empty", 64'(rd_empty), 64'd1);
        check("rst.full", 64'(wr_full), 64'd0);
`ifdef ASYNC_FIFO_LEVEL_EN
        check("rst.level", 64'(level), 64'd0);
`endif
        wr_en = 1'b0;
        rd_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Three writes then three pops in order.
        cycle("w_a1", 1'b1, 32'hA1, 1'b0);
        check("first_word", 64'(rd_data), 64'hA1);
        cycle("w_a2", 1'b1, 32'hA2, 1'b0);
        cycle("w_a3", 1'b1, 32'hA3, 1'b0);
        check("pop0", 64'(rd_data), 64'hA1);
        cycle("r0", 1'b0, '0, 1'b1);
        check("pop1", 64'(rd_data), 64'hA2);
        cycle("r1", 1'b0, '0, 1'b1);
        check("pop2", 64'(rd_data), 64'hA3);
        cycle("r2", 1'b0, '0, 1'b1);
        check("after_pops_empty", 64'(rd_empty), 64'd1);

        // Fill, overflow attempt, drain.
        for (int i = 0; i < D; i++) cycle("fill", 1'b1, 32'hB0 + 32'(i), 1'b0);
        check("full_after_8", 64'(wr_full), 64'd1);
        cycle("overflow", 1'b1, 32'hFF, 1'b0);
        for (int i = 0; i < D; i++) begin
            check("drain_order", 64'(rd_data), 64'hB0 + 64'(i));
            cycle("drain8", 1'b0, '0, 1'b1);
        end
        check("drained_empty", 64'(rd_empty), 64'd1);

        // Simultaneous request while full.
        for (int i = 0; i < D; i++) cycle("fill2", 1'b1, 32'hC0 + 32'(i), 1'b0);
        cycle("full_wr_rd", 1'b1, 32'hEE, 1'b1);
        check("full_wr_rd.full", 64'(wr_full), 64'd0);
        check("full_wr_rd.head", 64'(rd_data), 64'hC1);
`ifdef ASYNC_FIFO_LEVEL_EN
        check("full_wr_rd.level", 64'(level), 64'd7);
`endif
        drain();

        // Simultaneous request while empty.
        cycle("empty_wr_rd", 1'b1, 32'h55, 1'b1);
        check("empty_wr_rd.data", 64'(rd_data), 64'h55);
        check("empty_wr_rd.empty", 64'(rd_empty), 64'd0);
        drain();

        // Interleaved traffic across pointer wrap.
        for (int i = 0; i < 20; i++) cycle("wrap", 1'b1, 32'h100 + 32'(i), (i % 3) != 0);
        drain();

        // Asynchronous reset mid-cycle while holding five words.
        for (int i = 0; i < 5; i++) cycle("pre_rst", 1'b1, 32'hD0 + 32'(i), 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_q.delete();
        check("async_rst.empty", 64'(rd_empty), 64'd1);
        check("async_rst.full", 64'(wr_full), 64'd0);
`ifdef ASYNC_FIFO_LEVEL_EN
        check("async_rst.level", 64'(level), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        cycle("post_rst", 1'b1, 32'h77, 1'b0);
        check("post_rst.data", 64'(rd_data), 64'h77);
        cycle("post_rst_pop", 1'b0, '0, 1'b1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cycle("rand", ($urandom_range(0, 99) < 55), $urandom, ($urandom_range(0, 99) < 50));
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
